// File: rtl/regfile_mp_if.sv
// Decode/writeback-side bus of the regfile_mp register file.
// The master side drives reads, writes and reservations; the slave side returns data and the scoreboard.
interface regfile_mp_if #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NUM_RD = 2
) ();
  localparam int AW = $clog2(NREGS);

  logic [NUM_RD-1:0]      rd_en;
  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_busy;
  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [XLEN-1:0]        wr_data;
  logic                   rsv_en;
  logic [AW-1:0]          rsv_addr;
  logic [NREGS-1:0]       busy_vec;
  logic                   rw_conflict;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_busy, busy_vec, rw_conflict
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_busy, busy_vec, rw_conflict
  );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file (x0 hardwired to zero) with a pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward wr_data to a colliding read instead of flagging rw_conflict.
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NUM_RD = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  regfile_mp_if.slave bus
);
  localparam int          AW      = $clog2(NREGS);
  localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

  logic [XLEN-1:0]        regs_r [NREGS];
  logic [NREGS-1:0]       busy_r;
  logic [NREGS-1:0]       busy_nxt_s;
  logic [NUM_RD*XLEN-1:0] rd_data_r;
  logic [NUM_RD*XLEN-1:0] rd_data_nxt_s;
  logic [NUM_RD-1:0]      rd_busy_r;
  logic [NUM_RD-1:0]      rd_busy_nxt_s;
  logic [AW-1:0]          port_addr_s [NUM_RD];
  logic [NUM_RD-1:0]      hit_s;
  logic                   wr_ok_s;
  logic                   conflict_s;

  // Address names a real, writable register: not x0 and below NREGS.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != {AW{1'b0}}) && ({1'b0, a} < NREGS_W);
  endfunction

  // Unpack read addresses and detect per-port read/write collisions.
  always_comb begin
    wr_ok_s = bus.wr_en && addr_ok(bus.wr_addr);
    for (int i = 0; i < NUM_RD; i++) begin
      port_addr_s[i] = bus.rd_addr[i*AW +: AW];
      hit_s[i]       = bus.rd_en[i] && wr_ok_s && (port_addr_s[i] == bus.wr_addr);
    end
  end

  // Next read-port contents; collisions either bypass or hold depending on the build.
  always_comb begin
    rd_data_nxt_s = rd_data_r;
    rd_busy_nxt_s = rd_busy_r;
    for (int i = 0; i < NUM_RD; i++) begin
      if (!bus.rd_en[i]) begin
        rd_data_nxt_s[i*XLEN +: XLEN] = rd_data_r[i*XLEN +: XLEN];
        rd_busy_nxt_s[i]              = rd_busy_r[i];
      end else if (hit_s[i]) begin
`ifdef REGFILE_BYPASS_EN
        rd_data_nxt_s[i*XLEN +: XLEN] = bus.wr_data;
        rd_busy_nxt_s[i]              = 1'b0;
`else
        rd_data_nxt_s[i*XLEN +: XLEN] = rd_data_r[i*XLEN +: XLEN];
        rd_busy_nxt_s[i]              = rd_busy_r[i];
`endif
      end else if (addr_ok(port_addr_s[i])) begin
        rd_data_nxt_s[i*XLEN +: XLEN] = regs_r[port_addr_s[i]];
        rd_busy_nxt_s[i]              = busy_r[port_addr_s[i]] &
                                        ~(bus.wr_en && (bus.wr_addr == port_addr_s[i]));
      end else begin
        rd_data_nxt_s[i*XLEN +: XLEN] = {XLEN{1'b0}};
        rd_busy_nxt_s[i]              = 1'b0;
      end
    end
  end

  // Scoreboard next state: a reservation beats a same-cycle release of the same register.
  always_comb begin
    busy_nxt_s = busy_r;
    for (int r = 1; r < NREGS; r++) begin
      if (bus.rsv_en && (bus.rsv_addr == AW'(r))) begin
        busy_nxt_s[r] = 1'b1;
      end else if (wr_ok_s && (bus.wr_addr == AW'(r))) begin
        busy_nxt_s[r] = 1'b0;
      end else begin
        busy_nxt_s[r] = busy_r[r];
      end
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Collision flag is only meaningful without bypass, and is quiet during reset.
  always_comb begin
`ifdef REGFILE_BYPASS_EN
    conflict_s = 1'b0;
`else
    if (!reset_n) begin
      conflict_s = 1'b0;
    end else begin
      conflict_s = |hit_s;
    end
`endif
  end

  // Register array storage; x0 is never written so it stays zero after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_r[r] <= {XLEN{1'b0}};
      end
    end else if (wr_ok_s) begin
      regs_r[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Read-port output registers and scoreboard register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_r <= {(NUM_RD*XLEN){1'b0}};
      rd_busy_r <= {NUM_RD{1'b0}};
      busy_r    <= {NREGS{1'b0}};
    end else begin
      rd_data_r <= rd_data_nxt_s;
      rd_busy_r <= rd_busy_nxt_s;
      busy_r    <= busy_nxt_s;
    end
  end

  assign bus.rd_data     = rd_data_r;
  assign bus.rd_busy     = rd_busy_r;
  assign bus.busy_vec    = busy_r;
  assign bus.rw_conflict = conflict_s;

endmodule
